// File: rtl/song_pkg.sv
// song_pkg: constants and helpers shared by the song sequencer and the
// piano top level (note mux, segDisplay, notes).
//   - note_e  : 4-bit note codes, REST=0, C4=1 .. C5=8
//   - state_e : sequencer FSM state encodings
//   - note_to_led() : note code -> one-hot LED (C4 -> bit 7 .. C5 -> bit 0)
package song_pkg;

  localparam int SONG_LEN_DEF = 15;
  localparam int DUR_W_DEF    = 3;

  typedef enum logic [3:0] {
    REST = 4'd0,
    C4   = 4'd1,
    D4   = 4'd2,
    E4   = 4'd3,
    F4   = 4'd4,
    G4   = 4'd5,
    A4   = 4'd6,
    B4   = 4'd7,
    C5   = 4'd8
  } note_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Low notes light the left-most LED; REST and illegal codes light nothing.
  function automatic logic [7:0] note_to_led(input logic [3:0] n);
    logic [7:0] led;
    led = 8'h00;
    case (n)
      4'd1: led = 8'b1000_0000;
      4'd2: led = 8'b0100_0000;
      4'd3: led = 8'b0010_0000;
      4'd4: led = 8'b0001_0000;
      4'd5: led = 8'b0000_1000;
      4'd6: led = 8'b0000_0100;
      4'd7: led = 8'b0000_0010;
      4'd8: led = 8'b0000_0001;
      default: led = 8'h00;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// song_sequencer_if: control pulses into the sequencer and its registered
// outputs.
//   BEAT/START/STOP/PAUSE : one-CLK pulses from the clock manager / buttons
//   note[3:0], Led[7:0]   : current note code and its one-hot LED pattern
//   playing, done         : status flags
// master = the driver of the control pulses, slave = song_sequencer.
interface song_sequencer_if;
  logic       BEAT;
  logic       START;
  logic       STOP;
  logic       PAUSE;
  logic [3:0] note;
  logic [7:0] Led;
  logic       playing;
  logic       done;

  modport master (output BEAT, START, STOP, PAUSE,
                  input  note, Led, playing, done);
  modport slave  (input  BEAT, START, STOP, PAUSE,
                  output note, Led, playing, done);
endinterface

// File: rtl/song_rom.sv
// song_rom: combinational song table (Ode to Joy, phrase 1).
//   idx_i  : entry index 0..SONG_LEN-1
//   note_o : note code of the entry (REST for out-of-range indices)
//   dur_o  : entry duration in tempo ticks
module song_rom
  import song_pkg::*;
#(
  parameter int SONG_LEN = SONG_LEN_DEF,
  parameter int DUR_W    = DUR_W_DEF,
  localparam int IDX_W   = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [3:0]       note_o,
  output logic [DUR_W-1:0] dur_o
);

  always_comb begin
    note_o = REST;
    dur_o  = DUR_W'(1);
    case (int'(idx_i))
      0:  begin note_o = E4; dur_o = DUR_W'(2); end
      1:  begin note_o = E4; dur_o = DUR_W'(2); end
      2:  begin note_o = F4; dur_o = DUR_W'(2); end
      3:  begin note_o = G4; dur_o = DUR_W'(2); end
      4:  begin note_o = G4; dur_o = DUR_W'(2); end
      5:  begin note_o = F4; dur_o = DUR_W'(2); end
      6:  begin note_o = E4; dur_o = DUR_W'(2); end
      7:  begin note_o = D4; dur_o = DUR_W'(2); end
      8:  begin note_o = C4; dur_o = DUR_W'(2); end
      9:  begin note_o = C4; dur_o = DUR_W'(2); end
      10: begin note_o = D4; dur_o = DUR_W'(2); end
      11: begin note_o = E4; dur_o = DUR_W'(2); end
      12: begin note_o = E4; dur_o = DUR_W'(3); end
      13: begin note_o = D4; dur_o = DUR_W'(1); end
      14: begin note_o = D4; dur_o = DUR_W'(4); end
      default: begin note_o = REST; dur_o = DUR_W'(1); end
    endcase
  end

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: autoplay source for the piano top level. Steps through
// song_rom on BEAT ticks and emits registered note / Led / status outputs.
//   CLK   : system clock
//   RESET : synchronous, active-high reset
//   bus   : song_sequencer_if.slave (BEAT/START/STOP/PAUSE in,
//           note/Led/playing/done out)
// Build option: define SONG_LOOP_EN to loop the song forever instead of
// stopping in DONE at the end.
module song_sequencer
  import song_pkg::*;
#(
  parameter int SONG_LEN = SONG_LEN_DEF,
  parameter int DUR_W    = DUR_W_DEF,
  localparam int IDX_W   = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  song_sequencer_if.slave   bus
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SONG_LEN - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [DUR_W-1:0] cnt_q,   cnt_d;
  // Effective duration of the entry at idx_q, loaded alongside idx so the
  // ROM is only looked up once, at the next-state index.
  logic [DUR_W-1:0] dur_q,   dur_d;
  logic [3:0]       note_q,  note_d;
  logic [7:0]       led_q,   led_d;
  logic             playing_q, playing_d;
  logic             done_q,    done_d;

  logic [3:0]       rom_note;
  logic [DUR_W-1:0] rom_dur;
  logic             last_tick;
  logic             gap_d;

  song_rom #(.SONG_LEN(SONG_LEN), .DUR_W(DUR_W)) u_rom (
    .idx_i  (idx_d),
    .note_o (rom_note),
    .dur_o  (rom_dur)
  );

  // A zero duration in the table would never terminate; play it as 1 tick.
  assign dur_d     = (rom_dur == '0) ? DUR_W'(1) : rom_dur;
  assign last_tick = (cnt_q == dur_q - DUR_W'(1));
  // Last tick of a multi-tick entry is silent so repeated notes separate.
  assign gap_d     = (dur_d >= DUR_W'(2)) && (cnt_d == dur_d - DUR_W'(1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    // STOP in IDLE is a no-op and must not mask a simultaneous START.
    if (bus.STOP && state_q != S_IDLE) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (bus.START) begin
      state_d = S_PLAY;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (bus.PAUSE && state_q == S_PLAY) begin
      state_d = S_PAUSED;
    end else if (bus.PAUSE && state_q == S_PAUSED) begin
      state_d = S_PLAY;
    end else if (bus.BEAT && state_q == S_PLAY) begin
      if (last_tick) begin
        cnt_d = '0;
        if (idx_q == IDX_LAST) begin
`ifdef SONG_LOOP_EN
          idx_d = '0;
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        cnt_d = cnt_q + DUR_W'(1);
      end
    end
  end

  // Outputs are decoded from next state so they land on the same edge as
  // the state change.
  always_comb begin
    note_d = REST;
    if (state_d == S_PLAY && !gap_d) note_d = rom_note;
    led_d     = note_to_led(note_d);
    playing_d = (state_d == S_PLAY);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      dur_q     <= DUR_W'(1);
      note_q    <= '0;
      led_q     <= '0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      dur_q     <= dur_d;
      note_q    <= note_d;
      led_q     <= led_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign bus.note    = note_q;
  assign bus.Led     = led_q;
  assign bus.playing = playing_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Testbench for song_sequencer. A tick-level reference model expands the
// song into 32 ticks; every driven cycle pushes the expected
// {note, Led, playing, done} into a scoreboard queue, which each test pops
// and compares after the clock edge.
module tb_song_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  song_sequencer_if bus();

  song_sequencer dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  int rn[15] = '{3, 3, 4, 5, 5, 4, 3, 2, 1, 1, 2, 3, 3, 2, 2};
  int rd[15] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3, 1, 4};
  int tn[32];  // expected note per tick (gap already applied)
  int te[32];  // entry index per tick
  int tc[32];  // tick-within-entry per tick

  typedef enum int {M_IDLE, M_PLAY, M_PAUSED, M_DONE} mst_t;
  mst_t mst;
  int   mp;

  logic [13:0] sb[$];
  logic [13:0] got, exp;

  function automatic logic [7:0] led_of(input int n);
    if (n == 0) return 8'h00;
    return 8'h80 >> (n - 1);
  endfunction

  function automatic logic [13:0] model_out(input mst_t s, input int p);
    int n;
    n = (s == M_PLAY) ? tn[p] : 0;
    return {4'(n), led_of(n), s == M_PLAY, s == M_DONE};
  endfunction

  // Drive one cycle of pulses, advance the model and queue its expectation.
  task automatic drive(input logic r, input logic b, input logic s,
                       input logic t, input logic p);
    rst = r; bus.BEAT = b; bus.START = s; bus.STOP = t; bus.PAUSE = p;
    if (r) begin mst = M_IDLE; mp = 0; end
    else if (t && mst != M_IDLE) begin mst = M_IDLE; mp = 0; end
    else if (s) begin mst = M_PLAY; mp = 0; end
    else if (p && mst == M_PLAY) mst = M_PAUSED;
    else if (p && mst == M_PAUSED) mst = M_PLAY;
    else if (b && mst == M_PLAY) begin
      if (mp == 31) begin
`ifdef SONG_LOOP_EN
        mp = 0;
`else
        mst = M_DONE;
`endif
      end else mp = mp + 1;
    end
    sb.push_back(model_out(mst, mp));
    @(posedge clk); #1;
    rst = 1'b0; bus.BEAT = 1'b0; bus.START = 1'b0; bus.STOP = 1'b0; bus.PAUSE = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, i[0], 0, 0, 0);
      got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL reset[%0d]: got=%h want=%h", i, got, exp); end
    end
    total++;
    if (dut.idx_q !== 4'd0) begin bad++; $display("FAIL reset_idx: got=%0d want=0", dut.idx_q); end
  endtask

  task automatic test_start_gap();
    drive(0, 0, 1, 0, 0);
    got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL start_first: got=%h want=%h", got, exp); end
    total++;
    if (bus.Led !== 8'b0010_0000 || bus.note !== 4'd3) begin
      bad++; $display("FAIL start_E: got note=%0d led=%b want note=3 led=00100000", bus.note, bus.Led);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 0);
      got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL start_beat[%0d]: got=%h want=%h", i, got, exp); end
    end
    total++;
    if (dut.idx_q !== 4'(te[mp])) begin bad++; $display("FAIL start_idx: got=%0d want=%0d", dut.idx_q, te[mp]); end
  endtask

  task automatic test_reset_mid_play();
    drive(0, 0, 1, 0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 10; i++) begin drive(0, 1, 0, 0, 0); void'(sb.pop_front()); end
    total++;
    if (dut.idx_q !== 4'd5) begin bad++; $display("FAIL midplay_idx5: got=%0d want=5", dut.idx_q); end
    drive(1, 1, 0, 0, 0);
    got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL midplay_reset: got=%h want=%h", got, exp); end
    total++;
    if (dut.idx_q !== 4'd0) begin bad++; $display("FAIL midplay_idx0: got=%0d want=0", dut.idx_q); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0);
      got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL midplay_beat[%0d]: got=%h want=%h", i, got, exp); end
    end
  endtask

  task automatic test_full_song();
    drive(0, 0, 1, 0, 0);
    got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL song_start: got=%h want=%h", got, exp); end
    for (int i = 0; i < 32; i++) begin
      drive(0, 1, 0, 0, 0);
      got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL song_beat[%0d]: got=%h want=%h", i, got, exp); end
    end
`ifdef SONG_LOOP_EN
    total++;
    if (dut.idx_q !== 4'd0 || bus.note !== 4'd3 || bus.done !== 1'b0 || bus.playing !== 1'b1) begin
      bad++; $display("FAIL loop_wrap: got idx=%0d note=%0d done=%b play=%b want 0 3 0 1",
                      dut.idx_q, bus.note, bus.done, bus.playing);
    end
`else
    total++;
    if (bus.done !== 1'b1 || bus.note !== 4'd0 || bus.playing !== 1'b0) begin
      bad++; $display("FAIL song_done: got done=%b note=%0d play=%b want 1 0 0", bus.done, bus.note, bus.playing);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0);
      got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL song_extra[%0d]: got=%h want=%h", i, got, exp); end
    end
    drive(0, 0, 1, 0, 0);
    got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL song_restart: got=%h want=%h", got, exp); end
  endtask

  task automatic test_pause();
    drive(0, 0, 1, 0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 6; i++) begin drive(0, 1, 0, 0, 0); void'(sb.pop_front()); end
    drive(0, 0, 0, 0, 1);
    got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL pause_enter: got=%h want=%h", got, exp); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0);
      got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL pause_beat[%0d]: got=%h want=%h", i, got, exp); end
    end
    drive(0, 0, 0, 0, 1);
    got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL pause_resume: got=%h want=%h", got, exp); end
    total++;
    if (dut.idx_q !== 4'd3 || dut.cnt_q !== 3'd0 || bus.note !== 4'd5) begin
      bad++; $display("FAIL pause_pos: got idx=%0d cnt=%0d note=%0d want 3 0 5", dut.idx_q, dut.cnt_q, bus.note);
    end
  endtask

  task automatic test_priority();
    drive(0, 0, 1, 0, 0); void'(sb.pop_front());
    drive(0, 1, 0, 0, 0); void'(sb.pop_front());
    drive(0, 1, 1, 1, 0);  // START+STOP in PLAY: STOP wins
    got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL prio_stop: got=%h want=%h", got, exp); end
    drive(0, 0, 0, 0, 1);  // PAUSE in IDLE ignored
    got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL prio_pause_idle: got=%h want=%h", got, exp); end
    drive(0, 0, 1, 1, 0);  // STOP in IDLE does not mask START
    got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL prio_stop_idle: got=%h want=%h", got, exp); end
    drive(0, 1, 0, 0, 1);  // PAUSE+BEAT: BEAT ignored
    got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL prio_pause_beat: got=%h want=%h", got, exp); end
    total++;
    if (dut.cnt_q !== 3'(tc[mp])) begin bad++; $display("FAIL prio_cnt: got=%0d want=%0d", dut.cnt_q, tc[mp]); end
    drive(0, 0, 0, 1, 0); void'(sb.pop_front());
  endtask

  task automatic test_back_to_back();
    logic r, b, s, t, p;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) < 1);
      b = ($urandom_range(0, 99) < 60);
      s = ($urandom_range(0, 99) < 3);
      t = ($urandom_range(0, 99) < 2);
      p = ($urandom_range(0, 99) < 5);
      drive(r, b, s, t, p);
      got = {bus.note, bus.Led, bus.playing, bus.done}; exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL b2b[%0d]: got=%h want=%h", i, got, exp); end
      if (mst == M_PLAY || mst == M_PAUSED) begin
        total++;
        if (dut.idx_q !== 4'(te[mp]) || dut.cnt_q !== 3'(tc[mp])) begin
          bad++; $display("FAIL b2b_pos[%0d]: got idx=%0d cnt=%0d want %0d %0d", i, dut.idx_q, dut.cnt_q, te[mp], tc[mp]);
        end
      end
    end
  endtask

  initial begin
    int k;
    k = 0;
    for (int e = 0; e < 15; e++)
      for (int c = 0; c < rd[e]; c++) begin
        tn[k] = (c == rd[e] - 1 && rd[e] >= 2) ? 0 : rn[e];
        te[k] = e;
        tc[k] = c;
        k++;
      end
    mst = M_IDLE; mp = 0;
    rst = 1'b1; bus.BEAT = 1'b0; bus.START = 1'b0; bus.STOP = 1'b0; bus.PAUSE = 1'b0;
    test_reset();
    test_start_gap();
    test_reset_mid_play();
    test_full_song();
    drive(0, 0, 0, 1, 0); void'(sb.pop_front());
    test_pause();
    test_priority();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
